// File: rtl/ring_counter_pkg.sv
// Shared constants and seed helper for the ring/Johnson counter family.
package ring_counter_pkg;

    localparam int unsigned SEED_MAX_W = 64;

    localparam logic MODE_RING    = 1'b0;
    localparam logic MODE_JOHNSON = 1'b1;

    localparam logic DIR_UP = 1'b0;
    localparam logic DIR_DN = 1'b1;

    // Ring seed is bit 0 set, Johnson seed is all zeros; callers cast to their width.
    function automatic logic [SEED_MAX_W-1:0] seed_of(input int unsigned width, input logic mode);
        seed_of = '0;
        if ((mode == MODE_RING) && (width >= 2)) begin
            seed_of[0] = 1'b1;
        end
    endfunction

endpackage

// File: rtl/ring_state_checker.sv
// Combinational legality check of a ring (one-hot) or Johnson state vector.
module ring_state_checker
    import ring_counter_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic [WIDTH-1:0] i_dout,
    input  logic             i_mode,
    output logic             o_illegal
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    logic [CW-1:0] w_ones;
    logic [CW-1:0] w_trans;

    // Ring needs exactly one set bit; Johnson allows at most one 0/1 boundary.
    always_comb begin
        w_ones  = '0;
        w_trans = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_ones = w_ones + CW'(i_dout[i]);
        end
        for (int i = 0; i < WIDTH - 1; i++) begin
            w_trans = w_trans + CW'(i_dout[i] ^ i_dout[i+1]);
        end
        if (i_mode == MODE_RING) begin
            o_illegal = (w_ones != CW'(1));
        end else begin
            o_illegal = (w_trans > CW'(1));
        end
    end

endmodule

// File: rtl/ring_counter_param.sv
// Parametrised ring/Johnson counter with load, direction, wrap pulse and illegal flag.
// Define RING_SELF_CORRECT_EN to reseed illegal states on the next enabled advance.
module ring_counter_param
    import ring_counter_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic             dir,
    input  logic             mode,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] dout,
    output logic             wrap,
    output logic             illegal
);

    logic [WIDTH-1:0] r_dout;
    logic             r_mode;
    logic             r_wrap;

    logic [WIDTH-1:0] w_seed;
    logic [WIDTH-1:0] w_shift;
    logic [WIDTH-1:0] w_next;
    logic             w_wrap_next;
    logic             w_illegal;

    ring_state_checker #(
        .WIDTH(WIDTH)
    ) u_checker (
        .i_dout    (r_dout),
        .i_mode    (mode),
        .o_illegal (w_illegal)
    );

    assign w_seed = WIDTH'(seed_of(WIDTH, mode));

    always_comb begin
        w_shift = r_dout;
        unique case ({mode, dir})
            {MODE_RING,    DIR_UP}: w_shift = {r_dout[WIDTH-2:0], r_dout[WIDTH-1]};
            {MODE_RING,    DIR_DN}: w_shift = {r_dout[0], r_dout[WIDTH-1:1]};
            {MODE_JOHNSON, DIR_UP}: w_shift = {r_dout[WIDTH-2:0], ~r_dout[WIDTH-1]};
            {MODE_JOHNSON, DIR_DN}: w_shift = {~r_dout[0], r_dout[WIDTH-1:1]};
            default:                w_shift = r_dout;
        endcase
    end

    // Priority: load, then mode-change reseed, then advance, else hold.
    always_comb begin
        w_next      = r_dout;
        w_wrap_next = 1'b0;
        if (load) begin
            w_next = load_val;
        end else if (mode != r_mode) begin
            w_next = w_seed;
        end else if (en) begin
`ifdef RING_SELF_CORRECT_EN
            if (w_illegal) begin
                w_next = w_seed;
            end else begin
                w_next      = w_shift;
                w_wrap_next = (w_shift == w_seed);
            end
`else
            w_next      = w_shift;
            w_wrap_next = (w_shift == w_seed);
`endif
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_dout <= WIDTH'(seed_of(WIDTH, MODE_RING));
            r_mode <= MODE_RING;
            r_wrap <= 1'b0;
        end else begin
            r_dout <= w_next;
            r_mode <= mode;
            r_wrap <= w_wrap_next;
        end
    end

    assign dout    = r_dout;
    assign wrap    = r_wrap;
    assign illegal = w_illegal;

endmodule

// File: tb/tb_ring_counter_param.sv
// Directed self-checking bench for ring_counter_param at WIDTH=4.
module tb_ring_counter_param;

    logic       clk;
    logic       reset_n;
    logic       en;
    logic       dir;
    logic       mode;
    logic       load;
    logic [3:0] load_val;
    logic [3:0] dout;
    logic       wrap;
    logic       illegal;

    int checks = 0;
    int errors = 0;

    ring_counter_param #(.WIDTH(4)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .en       (en),
        .dir      (dir),
        .mode     (mode),
        .load     (load),
        .load_val (load_val),
        .dout     (dout),
        .wrap     (wrap),
        .illegal  (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; en = 1'b0; dir = 1'b0; mode = 1'b0; load = 1'b0; load_val = 4'b0000;
        #12;
        checks++;
        if (dout !== 4'b0001) begin errors++; $display("FAIL reset_dout got %b want 0001", dout); end
        checks++;
        if (wrap !== 1'b0) begin errors++; $display("FAIL reset_wrap got %b want 0", wrap); end
        checks++;
        if (illegal !== 1'b0) begin errors++; $display("FAIL reset_illegal got %b want 0", illegal); end
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_ring_up();
        logic [3:0] exp_d [8] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001,
                                  4'b0010, 4'b0100, 4'b1000, 4'b0001};
        mode = 1'b0; dir = 1'b0; en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            checks++;
            if (dout !== exp_d[i]) begin errors++; $display("FAIL ring_up_dout[%0d] got %b want %b", i, dout, exp_d[i]); end
            checks++;
            if (wrap !== (exp_d[i] == 4'b0001)) begin errors++; $display("FAIL ring_up_wrap[%0d] got %b want %b", i, wrap, exp_d[i] == 4'b0001); end
        end
        step();
        step();
        checks++;
        if (dout !== 4'b0100) begin errors++; $display("FAIL ring_pre_reset got %b want 0100", dout); end
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if (dout !== 4'b0001) begin errors++; $display("FAIL async_reset_dout got %b want 0001", dout); end
        checks++;
        if (wrap !== 1'b0) begin errors++; $display("FAIL async_reset_wrap got %b want 0", wrap); end
        #1;
        reset_n = 1'b1;
        en = 1'b0;
    endtask

    task automatic test_johnson();
        logic [3:0] exp_d [9] = '{4'b0000, 4'b0001, 4'b0011, 4'b0111, 4'b1111,
                                  4'b1110, 4'b1100, 4'b1000, 4'b0000};
        mode = 1'b1; dir = 1'b0; en = 1'b1;
        for (int i = 0; i < 9; i++) begin
            step();
            checks++;
            if (dout !== exp_d[i]) begin errors++; $display("FAIL johnson_dout[%0d] got %b want %b", i, dout, exp_d[i]); end
            checks++;
            if (wrap !== (i == 8)) begin errors++; $display("FAIL johnson_wrap[%0d] got %b want %b", i, wrap, i == 8); end
            checks++;
            if (illegal !== 1'b0) begin errors++; $display("FAIL johnson_illegal[%0d] got %b want 0", i, illegal); end
        end
        mode = 1'b0;
        step();
        checks++;
        if (dout !== 4'b0001) begin errors++; $display("FAIL johnson_to_ring got %b want 0001", dout); end
        checks++;
        if (wrap !== 1'b0) begin errors++; $display("FAIL johnson_to_ring_wrap got %b want 0", wrap); end
    endtask

    task automatic test_dir_toggle();
        logic [3:0] exp_d [3] = '{4'b0010, 4'b0001, 4'b1000};
        logic       exp_w [3] = '{1'b0, 1'b1, 1'b0};
        mode = 1'b0; dir = 1'b0; en = 1'b1;
        step();
        step();
        checks++;
        if (dout !== 4'b0100) begin errors++; $display("FAIL dir_setup got %b want 0100", dout); end
        dir = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (dout !== exp_d[i]) begin errors++; $display("FAIL dir_dn_dout[%0d] got %b want %b", i, dout, exp_d[i]); end
            checks++;
            if (wrap !== exp_w[i]) begin errors++; $display("FAIL dir_dn_wrap[%0d] got %b want %b", i, wrap, exp_w[i]); end
        end
        dir = 1'b0;
    endtask

    task automatic test_load();
        logic [3:0] exp_next;
        logic       exp_ill;
`ifdef RING_SELF_CORRECT_EN
        exp_next = 4'b0001; exp_ill = 1'b0;
`else
        exp_next = 4'b1100; exp_ill = 1'b1;
`endif
        mode = 1'b0; dir = 1'b0; en = 1'b1; load = 1'b1; load_val = 4'b0110;
        step();
        load = 1'b0;
        checks++;
        if (dout !== 4'b0110) begin errors++; $display("FAIL load_dout got %b want 0110", dout); end
        checks++;
        if (illegal !== 1'b1) begin errors++; $display("FAIL load_illegal got %b want 1", illegal); end
        checks++;
        if (wrap !== 1'b0) begin errors++; $display("FAIL load_wrap got %b want 0", wrap); end
        step();
        checks++;
        if (dout !== exp_next) begin errors++; $display("FAIL post_load_dout got %b want %b", dout, exp_next); end
        checks++;
        if (wrap !== 1'b0) begin errors++; $display("FAIL post_load_wrap got %b want 0", wrap); end
        checks++;
        if (illegal !== exp_ill) begin errors++; $display("FAIL post_load_illegal got %b want %b", illegal, exp_ill); end
    endtask

    task automatic test_mode_switch();
        mode = 1'b0; en = 1'b1; load = 1'b1; load_val = 4'b0100;
        step();
        load = 1'b0;
        checks++;
        if (dout !== 4'b0100) begin errors++; $display("FAIL switch_setup got %b want 0100", dout); end
        mode = 1'b1;
        step();
        checks++;
        if (dout !== 4'b0000) begin errors++; $display("FAIL switch_dout got %b want 0000", dout); end
        checks++;
        if (wrap !== 1'b0) begin errors++; $display("FAIL switch_wrap got %b want 0", wrap); end
        checks++;
        if (illegal !== 1'b0) begin errors++; $display("FAIL switch_illegal got %b want 0", illegal); end
    endtask

    task automatic test_johnson_legality();
        logic [3:0] vals [4] = '{4'b0101, 4'b0011, 4'b1100, 4'b1010};
        logic       ills [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        mode = 1'b1; en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            load = 1'b1; load_val = vals[i];
            step();
            checks++;
            if (illegal !== ills[i]) begin errors++; $display("FAIL johnson_legal[%b] got %b want %b", vals[i], illegal, ills[i]); end
        end
        load = 1'b0;
        mode = 1'b0;
        step();
        checks++;
        if (dout !== 4'b0001) begin errors++; $display("FAIL legality_exit got %b want 0001", dout); end
    endtask

    task automatic test_hold();
        mode = 1'b0; dir = 1'b0; en = 1'b1;
        step();
        checks++;
        if (dout !== 4'b0010) begin errors++; $display("FAIL hold_setup got %b want 0010", dout); end
        en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            checks++;
            if (dout !== 4'b0010) begin errors++; $display("FAIL hold_dout[%0d] got %b want 0010", i, dout); end
            checks++;
            if (wrap !== 1'b0) begin errors++; $display("FAIL hold_wrap[%0d] got %b want 0", i, wrap); end
        end
    endtask

    task automatic test_back_to_back();
        // A wrap pulse must last exactly one cycle even with en held high.
        mode = 1'b0; dir = 1'b1; en = 1'b1;
        step();
        checks++;
        if ((dout !== 4'b0001) || (wrap !== 1'b1)) begin errors++; $display("FAIL b2b_wrap got %b/%b want 0001/1", dout, wrap); end
        step();
        checks++;
        if ((dout !== 4'b1000) || (wrap !== 1'b0)) begin errors++; $display("FAIL b2b_after got %b/%b want 1000/0", dout, wrap); end
        en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_ring_up();
        test_johnson();
        test_dir_toggle();
        test_load();
        test_mode_switch();
        test_johnson_legality();
        test_hold();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
